// File: rtl/memoredf_pkg.sv
// Shared constants and helpers for the deadline tracker.
package memoredf_pkg;

  localparam int unsigned MISS_CNT_W  = 16;
  localparam int unsigned MAX_VALUE_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } queue_state_e;

  // All-ones deadline of the given width (idle queues never win a min-compare).
  function automatic logic [MAX_VALUE_W-1:0] idle_deadline(input int unsigned width);
    return {MAX_VALUE_W{1'b1}} >> (MAX_VALUE_W - width);
  endfunction

endpackage

// File: rtl/deadline_counter.sv
// Per-queue deadline state: idle/armed, countdown value, sticky miss flag.
// Optional saturating miss counter when DEADLINE_MISS_COUNT_EN is defined.
module deadline_counter
  import memoredf_pkg::*;
#(
  parameter int unsigned VALUE_SIZE = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [VALUE_SIZE-1:0] period,
  input  logic                  pending,
  input  logic                  grant,
  output logic [VALUE_SIZE-1:0] deadline,
  output logic                  miss,
  output logic [MISS_CNT_W-1:0] miss_count
);

  localparam logic [VALUE_SIZE-1:0] IDLE_VALUE = VALUE_SIZE'(idle_deadline(VALUE_SIZE));

  queue_state_e          state_q;
  queue_state_e          state_d;
  logic [VALUE_SIZE-1:0] value_d;
  logic                  miss_event;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      deadline <= IDLE_VALUE;
      miss     <= 1'b0;
    end else begin
      state_q  <= state_d;
      deadline <= value_d;
      miss     <= miss | miss_event;
    end
  end

  // Grant beats pending-drop, which beats arming and the tick countdown.
  always_comb begin
    state_d    = state_q;
    value_d    = deadline;
    miss_event = 1'b0;
    if (grant) begin
      if (pending) begin
        state_d = ST_ARMED;
        value_d = period;
      end else begin
        state_d = ST_IDLE;
        value_d = IDLE_VALUE;
      end
    end else if (!pending) begin
      state_d = ST_IDLE;
      value_d = IDLE_VALUE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARMED;
          value_d = period;
        end
        ST_ARMED: begin
          if (tick) begin
            if (deadline == '0) begin
              miss_event = 1'b1;
            end else begin
              value_d = deadline - VALUE_SIZE'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          value_d = IDLE_VALUE;
        end
      endcase
    end
  end

`ifdef DEADLINE_MISS_COUNT_EN
  logic [MISS_CNT_W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (miss_event && (count_q != '1)) begin
      count_q <= count_q + MISS_CNT_W'(1);
    end
  end

  assign miss_count = count_q;
`else
  assign miss_count = '0;
`endif

endmodule

// File: rtl/deadline_tracker.sv
// Per-queue relative-deadline tracker with a shared tick prescaler.
// Define DEADLINE_MISS_COUNT_EN to build the per-queue miss counters.
module deadline_tracker
  import memoredf_pkg::*;
#(
  parameter int unsigned NB_QUEUES  = 4,
  parameter int unsigned VALUE_SIZE = 4,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NB_QUEUES*VALUE_SIZE-1:0] in_period,
  input  logic [NB_QUEUES-1:0]            in_pending,
  input  logic [NB_QUEUES-1:0]            in_grant,
  input  logic                            in_grant_valid,
  output logic [NB_QUEUES*VALUE_SIZE-1:0] out_deadline,
  output logic [NB_QUEUES-1:0]            out_miss,
  output logic [NB_QUEUES*MISS_CNT_W-1:0] out_miss_count
);

  localparam int unsigned PRESC_W = 8;

  if ((TICK_DIV < 1) || (TICK_DIV > 255)) begin : g_bad_tick_div
    $error("TICK_DIV must be in 1..255");
  end

  logic [PRESC_W-1:0] presc_q;
  logic               tick;

  assign tick = (presc_q == PRESC_W'(TICK_DIV - 1));

  // Shared prescaler: counts 0..TICK_DIV-1, tick on the wrap cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

  for (genvar i = 0; i < NB_QUEUES; i++) begin : g_queue
    deadline_counter #(
      .VALUE_SIZE (VALUE_SIZE)
    ) u_counter (
      .clock      (clock),
      .reset      (reset),
      .tick       (tick),
      .period     (in_period[i*VALUE_SIZE +: VALUE_SIZE]),
      .pending    (in_pending[i]),
      .grant      (in_grant_valid & in_grant[i]),
      .deadline   (out_deadline[i*VALUE_SIZE +: VALUE_SIZE]),
      .miss       (out_miss[i]),
      .miss_count (out_miss_count[i*MISS_CNT_W +: MISS_CNT_W])
    );
  end

endmodule

// File: tb/tb_deadline_tracker.sv
// Directed bench: one tracker at TICK_DIV=1 and one at TICK_DIV=3.
module tb_deadline_tracker;

  localparam int unsigned NQ = 4;
  localparam int unsigned VS = 4;
  localparam int unsigned CW = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset;
  logic [NQ*VS-1:0]  period_a, period_b;
  logic [NQ-1:0]     pending_a, pending_b;
  logic [NQ-1:0]     grant_a, grant_b;
  logic              grant_valid_a, grant_valid_b;
  logic [NQ*VS-1:0]  deadline_a, deadline_b;
  logic [NQ-1:0]     miss_a, miss_b;
  logic [NQ*CW-1:0]  count_a, count_b;

  int checks = 0;
  int passes = 0;

  deadline_tracker #(.NB_QUEUES(NQ), .VALUE_SIZE(VS), .TICK_DIV(1)) dut_a (
    .clock          (clock),
    .reset          (reset),
    .in_period      (period_a),
    .in_pending     (pending_a),
    .in_grant       (grant_a),
    .in_grant_valid (grant_valid_a),
    .out_deadline   (deadline_a),
    .out_miss       (miss_a),
    .out_miss_count (count_a)
  );

  deadline_tracker #(.NB_QUEUES(NQ), .VALUE_SIZE(VS), .TICK_DIV(3)) dut_b (
    .clock          (clock),
    .reset          (reset),
    .in_period      (period_b),
    .in_pending     (pending_b),
    .in_grant       (grant_b),
    .in_grant_valid (grant_valid_b),
    .out_deadline   (deadline_b),
    .out_miss       (miss_b),
    .out_miss_count (count_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passes++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] cnt_exp(input logic [63:0] v);
`ifdef DEADLINE_MISS_COUNT_EN
    return v;
`else
    return 64'd0 & v;
`endif
  endfunction

  initial begin
    reset = 1'b1;
    period_a = '0; pending_a = '0; grant_a = '0; grant_valid_a = 1'b0;
    period_b = '0; pending_b = '0; grant_b = '0; grant_valid_b = 1'b0;
    step();
    step();
    check("b_reset_deadline", 64'(deadline_b), 64'hFFFF);
    check("b_reset_miss", 64'(miss_b), 64'h0);

    // Prescaler: arm on the cycle the prescaler sits at 0 (first cycle out of reset).
    reset = 1'b0; period_b = 16'h0006; pending_b = 4'b0001;
    step();
    check("b_arm", 64'(deadline_b), 64'hFFF6);
    step();
    check("b_before_first_tick", 64'(deadline_b[3:0]), 64'd6);
    step();
    check("b_first_dec", 64'(deadline_b[3:0]), 64'd5);
    repeat (14) step();
    check("b_arm_plus_17", 64'(deadline_b[3:0]), 64'd1);
    step();
    check("b_zero_at_18", 64'(deadline_b[3:0]), 64'd0);
    step();
    step();
    check("b_no_miss_before_tick", 64'(miss_b), 64'h0);
    step();
    check("b_miss_on_tick", 64'(miss_b), 64'h1);

    reset = 1'b1; pending_b = '0;
    step();
    check("a_reset_deadline", 64'(deadline_a), 64'hFFFF);
    check("a_reset_miss", 64'(miss_a), 64'h0);
    check("a_reset_count", 64'(count_a), 64'h0);

    // q0 period 5, q1 all-ones, q2 zero, q3 stays idle.
    reset = 1'b0; period_a = 16'h30F5; pending_a = 4'b0111;
    step();
    check("a_arm", 64'(deadline_a), 64'hF0F5);
    check("a_arm_miss", 64'(miss_a), 64'h0);
    step();
    check("a_dec", 64'(deadline_a), 64'hF0E4);
    check("a_zero_period_miss", 64'(miss_a), 64'h4);
    repeat (4) step();
    check("a_sat_zero", 64'(deadline_a), 64'hF0A0);
    step();
    check("a_hold_zero", 64'(deadline_a), 64'hF090);
    check("a_miss_q0", 64'(miss_a), 64'h5);
    check("a_count_q0_first", 64'(count_a[15:0]), cnt_exp(64'd1));
    check("a_count_q2", 64'(count_a[47:32]), cnt_exp(64'd6));
    step();
    check("a_count_q0_second", 64'(count_a[15:0]), cnt_exp(64'd2));

    period_a[3:0] = 4'd7; grant_a = 4'b0001; grant_valid_a = 1'b1;
    step();
    check("a_grant_reload", 64'(deadline_a[3:0]), 64'd7);
    check("a_grant_blocks_count", 64'(count_a[15:0]), cnt_exp(64'd2));
    check("a_miss_sticky", 64'(miss_a), 64'h5);

    pending_a[0] = 1'b0;
    step();
    check("a_grant_to_idle", 64'(deadline_a[3:0]), 64'hF);

    grant_a = 4'b0010; grant_valid_a = 1'b0;
    step();
    check("a_grant_ignored", 64'(deadline_a[7:4]), 64'd5);

    grant_a = 4'b0110; grant_valid_a = 1'b1; period_a[7:4] = 4'd9; period_a[11:8] = 4'd3;
    step();
    check("a_multi_grant", 64'(deadline_a), 64'hF39F);
    check("a_multi_grant_count", 64'(count_a[47:32]), cnt_exp(64'd10));

    grant_a = '0; grant_valid_a = 1'b0; pending_a[1] = 1'b0;
    pending_a[3] = 1'b1; period_a[15:12] = 4'd0;
    step();
    check("a_drop_pending", 64'(deadline_a), 64'h02FF);

    // Grant and tick land on q3 while it sits at 0.
    grant_a = 4'b1000; grant_valid_a = 1'b1; period_a[15:12] = 4'd2;
    step();
    check("a_collision_reload", 64'(deadline_a[15:12]), 64'd2);
    check("a_collision_no_miss", 64'(miss_a), 64'h5);
    grant_a = '0; grant_valid_a = 1'b0;
    step();
    check("a_after_collision", 64'(deadline_a[15:12]), 64'd1);

    reset = 1'b1; pending_a = '0;
    step();
    check("a_midrun_reset_deadline", 64'(deadline_a), 64'hFFFF);
    check("a_midrun_reset_miss", 64'(miss_a), 64'h0);
    check("a_midrun_reset_count", 64'(count_a), 64'h0);
    reset = 1'b0;
    step();
    check("a_idle_after_reset", 64'(deadline_a), 64'hFFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/deadline_tracker.md
DEADLINE_TRACKER -- requirements
Module: deadline_tracker

Interface
REQ-001 Parameter NB_QUEUES, default 4: number of tracked request queues.
REQ-002 Parameter VALUE_SIZE, default 4: width of each deadline value. Same width as the min-selection tree that consumes it.
REQ-003 Parameter TICK_DIV, default 1: clock cycles per deadline decrement; legal range is 1 to 255.
REQ-004 Port: clock, input, 1 bit. The single clock.
REQ-005 Port: reset, input, 1 bit. Synchronous, active-high.
REQ-006 Port: in_period, input, NB_QUEUES*VALUE_SIZE bits. Relative deadline per queue; slice i = [i*VALUE_SIZE +: VALUE_SIZE].
REQ-007 Port: in_pending, input, NB_QUEUES bits. Queue i holds at least one request.
REQ-008 Port: in_grant, input, NB_QUEUES bits. One-hot; the queue served this cycle.
REQ-009 Port: in_grant_valid, input, 1 bit. Qualifies in_grant.
REQ-010 Port: out_deadline, output, NB_QUEUES*VALUE_SIZE bits. Current deadline per queue; same slicing as in_period.
REQ-011 Port: out_miss, output, NB_QUEUES bits. Sticky deadline-miss flag per queue.
REQ-012 Port: out_miss_count, output, NB_QUEUES*16 bits. Per-queue miss counters.

Function
REQ-013 Idle queue (in_pending[i]=0) SHALL hold deadline all-ones, so it never wins a minimum comparison.
REQ-014 Arm: on the first cycle with in_pending[i]=1 while idle, deadline[i] SHALL load in_period[i]; the new value is visible on the next cycle.
REQ-015 Tick: a prescaler SHALL count 0..TICK_DIV-1 and assert tick for one cycle on wrap; TICK_DIV=1 means tick every cycle.
REQ-016 Countdown: on tick, an armed queue not granted that cycle SHALL decrement by 1, saturating at 0.
REQ-017 Miss: on tick, an armed queue at 0 and not granted SHALL set out_miss[i]. The flag stays set until reset.
REQ-018 Grant: when in_grant_valid=1 and in_grant[i]=1:
- if in_pending[i]=1 that cycle, deadline[i] SHALL reload in_period[i];
- otherwise it SHALL return to idle (all-ones).
REQ-019 Grant has priority over tick decrement and miss detection in the same cycle.
REQ-020 in_pending[i] falling without a grant SHALL return queue i to idle.
REQ-021 in_grant bits with in_grant_valid=0 SHALL be ignored.
REQ-022 A non-one-hot in_grant SHALL be applied to each set bit independently.
REQ-023 An armed queue with in_period[i]=all-ones SHALL be legal and counts down normally.
REQ-024 in_period[i]=0 SHALL arm at 0; the next tick without a grant flags a miss.
REQ-025 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-026 In any cycle with reset=1, the following SHALL take their reset values on the next edge, regardless of in-flight grants or ticks:
- every deadline = all-ones (idle);
- out_miss = 0;
- out_miss_count = 0;
- prescaler = 0.
REQ-027 The first tick after reset deasserts SHALL occur TICK_DIV cycles later.

Configuration
REQ-028 Macro DEADLINE_MISS_COUNT_EN defined: each miss event of REQ-017 SHALL increment out_miss_count slice i, saturating at 16'hFFFF.
REQ-029 Macro DEADLINE_MISS_COUNT_EN undefined: out_miss_count SHALL be constant 0 and no counter registers are synthesised. out_miss is unaffected.

Structure
REQ-030 Package memoredf_pkg SHALL hold:
- the miss-counter width constant (16);
- the idle-deadline helper function (all-ones of VALUE_SIZE).
REQ-031 Sub-module deadline_counter SHALL implement one queue's state (idle/armed, value, miss flag, optional miss counter). It is instantiated NB_QUEUES times via generate.
REQ-032 The prescaler SHALL be shared, in the top level.

Verification
REQ-033 Arm test: reset, period0=5, pending0 rises at cycle 10 -> deadline0=5 at cycle 11, 4 at 12, saturates at 0 by cycle 16.
REQ-034 Miss test: same as REQ-033 with no grant -> out_miss[0]=1 at cycle 17. With macro defined, miss_count0 increments by 1 per cycle thereafter.
REQ-035 Grant test: grant0 with pending0 held and period0=7 -> deadline0=7 next cycle. Grant0 with pending0=0 -> 4'hF.
REQ-036 Prescaler test: TICK_DIV=3, period=6 -> deadline decrements once every 3 cycles; it reaches 0 exactly 18 cycles after arm.
REQ-037 Collision test: grant and tick on a queue at 0 in the same cycle -> reload, out_miss stays 0.
REQ-038 Reset test: reset mid-countdown with out_miss set -> all deadlines 4'hF, out_miss=0, out_miss_count=0 next cycle.
